// File: rtl/sdr_cpu_responder.sv
// Memory-side responder for the CPU SDRAM port: captures single-cycle requests, serves reads
// from a one-line burst buffer and forwards misses/writes to the SDRAM controller channel.
module sdr_cpu_responder #(
  parameter int LINE_WORDS = 4
) (
  input  logic        CLK_96M,
  input  logic        reset_n,
  input  logic [24:1] sdr_cpu_addr,
  input  logic [15:0] sdr_cpu_din,
  input  logic [1:0]  sdr_cpu_wr_sel,
  input  logic        sdr_cpu_req,
  output logic [15:0] sdr_cpu_dout,
  output logic        sdr_cpu_rdy,
  output logic [24:1] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_be,
  output logic        mem_we,
  output logic        mem_burst,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid,
  input  logic        cache_en,
  input  logic        cache_flush,
  output logic        err_overrun
);

  localparam int LW = $clog2(LINE_WORDS);
  localparam int TW = 24 - LW;

  typedef enum logic [2:0] {IDLE, HIT, RD_REQ, RD_DATA, WR_REQ, DONE} state_t;

  state_t          state_r;
  logic [24:1]     addr_r;
  logic            burst_r;
  logic            flushed_r;
  logic            valid_r;
  logic [TW-1:0]   tag_r;
  logic [15:0]     line_r [LINE_WORDS];
  logic [LW-1:0]   cnt_r;
  logic [15:0]     dout_r;
  logic            rdy_r;
  logic [24:1]     mem_addr_r;
  logic [15:0]     mem_wdata_r;
  logic [1:0]      mem_be_r;
  logic            mem_we_r;
  logic            mem_burst_r;
  logic            mem_req_r;
  logic            err_overrun_r;

  logic [TW-1:0]   req_tag_s;
  logic [LW-1:0]   req_idx_s;
  logic [LW-1:0]   cap_idx_s;
  logic            tag_match_s;
  logic            hit_s;

  // Byte-lane merge of a CPU write into a buffered line word.
  function automatic logic [15:0] merge_bytes(input logic [15:0] old_w, input logic [15:0] new_w,
                                              input logic [1:0] be);
    merge_bytes = {be[1] ? new_w[15:8] : old_w[15:8], be[0] ? new_w[7:0] : old_w[7:0]};
  endfunction

  assign req_tag_s   = sdr_cpu_addr[24:LW+1];
  assign req_idx_s   = sdr_cpu_addr[LW:1];
  assign cap_idx_s   = addr_r[LW:1];
  assign tag_match_s = valid_r && (tag_r == req_tag_s);
  // A flush on the lookup edge forces a miss so stale data is never returned.
  assign hit_s       = cache_en && tag_match_s && !cache_flush;

  // Request FSM, line buffer and registered controller/CPU outputs.
  always_ff @(posedge CLK_96M or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      addr_r        <= 24'h000000;
      burst_r       <= 1'b0;
      flushed_r     <= 1'b0;
      valid_r       <= 1'b0;
      tag_r         <= '0;
      cnt_r         <= '0;
      dout_r        <= 16'h0000;
      rdy_r         <= 1'b0;
      mem_addr_r    <= 24'h000000;
      mem_wdata_r   <= 16'h0000;
      mem_be_r      <= 2'b00;
      mem_we_r      <= 1'b0;
      mem_burst_r   <= 1'b0;
      mem_req_r     <= 1'b0;
      err_overrun_r <= 1'b0;
      for (int i = 0; i < LINE_WORDS; i++) line_r[i] <= 16'h0000;
    end else begin
      rdy_r <= 1'b0;
      if (cache_flush) valid_r <= 1'b0;
      if (sdr_cpu_req && (state_r != IDLE)) err_overrun_r <= 1'b1;
      case (state_r)
        IDLE: begin
          if (sdr_cpu_req) begin
            addr_r    <= sdr_cpu_addr;
            flushed_r <= 1'b0;
            if (sdr_cpu_wr_sel != 2'b00) begin
              state_r     <= WR_REQ;
              mem_req_r   <= 1'b1;
              mem_we_r    <= 1'b1;
              mem_be_r    <= sdr_cpu_wr_sel;
              mem_wdata_r <= sdr_cpu_din;
              mem_addr_r  <= sdr_cpu_addr;
              mem_burst_r <= 1'b0;
              burst_r     <= 1'b0;
              if (tag_match_s)
                line_r[req_idx_s] <= merge_bytes(line_r[req_idx_s], sdr_cpu_din, sdr_cpu_wr_sel);
            end else if (hit_s) begin
              state_r <= HIT;
            end else begin
              state_r   <= RD_REQ;
              mem_req_r <= 1'b1;
              mem_we_r  <= 1'b0;
              mem_be_r  <= 2'b00;
              if (cache_en) begin
                // Old line words get overwritten during the fill, so drop validity now.
                mem_burst_r <= 1'b1;
                mem_addr_r  <= {req_tag_s, {LW{1'b0}}};
                burst_r     <= 1'b1;
                valid_r     <= 1'b0;
                cnt_r       <= '0;
              end else begin
                mem_burst_r <= 1'b0;
                mem_addr_r  <= sdr_cpu_addr;
                burst_r     <= 1'b0;
              end
            end
          end
        end
        HIT: begin
          dout_r  <= line_r[cap_idx_s];
          rdy_r   <= 1'b1;
          state_r <= DONE;
        end
        RD_REQ: begin
          if (burst_r && cache_flush) flushed_r <= 1'b1;
          if (mem_ack) begin
            mem_req_r   <= 1'b0;
            mem_burst_r <= 1'b0;
            state_r     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (burst_r) begin
            if (cache_flush) flushed_r <= 1'b1;
            if (mem_rvalid) begin
              line_r[cnt_r] <= mem_rdata;
              if (cnt_r == cap_idx_s) dout_r <= mem_rdata;
              cnt_r <= cnt_r + LW'(1);
              if (cnt_r == LW'(LINE_WORDS - 1)) begin
                valid_r <= !(flushed_r || cache_flush);
                tag_r   <= addr_r[24:LW+1];
                rdy_r   <= 1'b1;
                state_r <= DONE;
              end
            end
          end else if (mem_rvalid) begin
            dout_r  <= mem_rdata;
            rdy_r   <= 1'b1;
            state_r <= DONE;
          end
        end
        WR_REQ: begin
          if (mem_ack) begin
            mem_req_r <= 1'b0;
            mem_we_r  <= 1'b0;
            mem_be_r  <= 2'b00;
            rdy_r     <= 1'b1;
            state_r   <= DONE;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign sdr_cpu_dout = dout_r;
  assign sdr_cpu_rdy  = rdy_r;
  assign mem_addr     = mem_addr_r;
  assign mem_wdata    = mem_wdata_r;
  assign mem_be       = mem_be_r;
  assign mem_we       = mem_we_r;
  assign mem_burst    = mem_burst_r;
  assign mem_req      = mem_req_r;
  assign err_overrun  = err_overrun_r;

endmodule

// File: tb/tb_sdr_cpu_responder.sv
// Directed bench for sdr_cpu_responder: misses, hits, write-update, flush, overrun and reset.
module tb_sdr_cpu_responder;

  logic        CLK_96M;
  logic        reset_n;
  logic [24:1] sdr_cpu_addr;
  logic [15:0] sdr_cpu_din;
  logic [1:0]  sdr_cpu_wr_sel;
  logic        sdr_cpu_req;
  logic [15:0] sdr_cpu_dout;
  logic        sdr_cpu_rdy;
  logic [24:1] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_be;
  logic        mem_we;
  logic        mem_burst;
  logic        mem_req;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic        cache_en;
  logic        cache_flush;
  logic        err_overrun;

  int n_assert = 0;
  int n_fail   = 0;
  int rdy_cnt  = 0;
  int rdy_mark = 0;

  sdr_cpu_responder #(.LINE_WORDS(4)) dut (
    .CLK_96M(CLK_96M), .reset_n(reset_n),
    .sdr_cpu_addr(sdr_cpu_addr), .sdr_cpu_din(sdr_cpu_din), .sdr_cpu_wr_sel(sdr_cpu_wr_sel),
    .sdr_cpu_req(sdr_cpu_req), .sdr_cpu_dout(sdr_cpu_dout), .sdr_cpu_rdy(sdr_cpu_rdy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_we(mem_we),
    .mem_burst(mem_burst), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .cache_en(cache_en), .cache_flush(cache_flush),
    .err_overrun(err_overrun)
  );

  initial CLK_96M = 1'b0;
  always #5 CLK_96M = ~CLK_96M;

  // Count completion pulses on the falling edge, away from the update edge.
  always @(negedge CLK_96M) if (sdr_cpu_rdy === 1'b1) rdy_cnt++;

  task automatic step();
    @(posedge CLK_96M);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [23:0] a, input logic [15:0] d, input logic [1:0] sel);
    sdr_cpu_addr   = a;
    sdr_cpu_din    = d;
    sdr_cpu_wr_sel = sel;
    sdr_cpu_req    = 1'b1;
    step();
    sdr_cpu_req    = 1'b0;
  endtask

  task automatic ack_once();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
  endtask

  task automatic feed(input logic [15:0] w);
    mem_rvalid = 1'b1;
    mem_rdata  = w;
    step();
    mem_rvalid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; sdr_cpu_addr = 24'h000000; sdr_cpu_din = 16'h0000; sdr_cpu_wr_sel = 2'b00;
    sdr_cpu_req = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0000; mem_rvalid = 1'b0;
    cache_en = 1'b1; cache_flush = 1'b0;
    step(); step(); step();
    chk("rst_rdy", 32'(sdr_cpu_rdy), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_dout", 32'(sdr_cpu_dout), 32'h0);
    chk("rst_err", 32'(err_overrun), 32'h0);
    reset_n = 1'b1;
    step();

    // Read miss on 0x000102: burst from 0x000100, word 2 returned.
    issue(24'h000102, 16'h0000, 2'b00);
    chk("miss_req", 32'(mem_req), 32'h1);
    chk("miss_burst", 32'(mem_burst), 32'h1);
    chk("miss_addr", 32'(mem_addr), 32'h000100);
    chk("miss_we", 32'(mem_we), 32'h0);
    step(); step();
    chk("miss_req_hold", 32'(mem_req), 32'h1);
    ack_once();
    chk("miss_req_drop", 32'(mem_req), 32'h0);
    rdy_mark = rdy_cnt;
    feed(16'hA0A0); feed(16'hA1A1); feed(16'hA2A2); feed(16'hA3A3);
    chk("miss_rdy", 32'(sdr_cpu_rdy), 32'h1);
    chk("miss_dout", 32'(sdr_cpu_dout), 32'hA2A2);
    step(); step();
    chk("miss_rdy_once", 32'(rdy_cnt - rdy_mark), 32'h1);

    // Hit on 0x000103: rdy two cycles after the request, no controller traffic.
    issue(24'h000103, 16'h0000, 2'b00);
    chk("hit_no_req", 32'(mem_req), 32'h0);
    chk("hit_rdy_early", 32'(sdr_cpu_rdy), 32'h0);
    step();
    chk("hit_rdy", 32'(sdr_cpu_rdy), 32'h1);
    chk("hit_dout", 32'(sdr_cpu_dout), 32'hA3A3);
    step();

    // Upper-byte write to 0x000101 updates the buffered line.
    issue(24'h000101, 16'hBEEF, 2'b10);
    chk("wr_req", 32'(mem_req), 32'h1);
    chk("wr_we", 32'(mem_we), 32'h1);
    chk("wr_be", 32'(mem_be), 32'h2);
    chk("wr_data", 32'(mem_wdata), 32'hBEEF);
    chk("wr_addr", 32'(mem_addr), 32'h000101);
    chk("wr_burst", 32'(mem_burst), 32'h0);
    ack_once();
    chk("wr_rdy", 32'(sdr_cpu_rdy), 32'h1);
    chk("wr_dout_hold", 32'(sdr_cpu_dout), 32'hA3A3);
    step();
    issue(24'h000101, 16'h0000, 2'b00);
    chk("wrhit_no_req", 32'(mem_req), 32'h0);
    step();
    chk("wrhit_rdy", 32'(sdr_cpu_rdy), 32'h1);
    chk("wrhit_dout", 32'(sdr_cpu_dout), 32'hBEA1);
    step();

    // Flush in the middle of the 0x000200 fill leaves the line invalid.
    issue(24'h000200, 16'h0000, 2'b00);
    chk("fl_addr", 32'(mem_addr), 32'h000200);
    ack_once();
    feed(16'hB0B0);
    cache_flush = 1'b1;
    feed(16'hB1B1);
    cache_flush = 1'b0;
    feed(16'hB2B2); feed(16'hB3B3);
    chk("fl_rdy", 32'(sdr_cpu_rdy), 32'h1);
    chk("fl_dout", 32'(sdr_cpu_dout), 32'hB0B0);
    step();
    issue(24'h000201, 16'h0000, 2'b00);
    chk("fl_refill_req", 32'(mem_req), 32'h1);
    chk("fl_refill_burst", 32'(mem_burst), 32'h1);
    chk("fl_refill_addr", 32'(mem_addr), 32'h000200);
    ack_once();
    feed(16'hC0C0); feed(16'hC1C1); feed(16'hC2C2); feed(16'hC3C3);
    chk("fl_refill_dout", 32'(sdr_cpu_dout), 32'hC1C1);
    step();

    // Second request during RD_DATA is dropped and flags an overrun.
    chk("ovr_err_clear", 32'(err_overrun), 32'h0);
    issue(24'h000300, 16'h0000, 2'b00);
    ack_once();
    rdy_mark = rdy_cnt;
    issue(24'h000301, 16'h0000, 2'b00);
    chk("ovr_err", 32'(err_overrun), 32'h1);
    chk("ovr_no_req", 32'(mem_req), 32'h0);
    feed(16'hD0D0); feed(16'hD1D1); feed(16'hD2D2); feed(16'hD3D3);
    chk("ovr_dout", 32'(sdr_cpu_dout), 32'hD0D0);
    step(); step(); step();
    chk("ovr_rdy_once", 32'(rdy_cnt - rdy_mark), 32'h1);
    chk("ovr_no_extra_req", 32'(mem_req), 32'h0);
    chk("ovr_err_sticky", 32'(err_overrun), 32'h1);

    // Reset while waiting for ack abandons the read and invalidates the line.
    issue(24'h000400, 16'h0000, 2'b00);
    chk("rr_req", 32'(mem_req), 32'h1);
    rdy_mark = rdy_cnt;
    reset_n = 1'b0;
    #2;
    chk("rr_req_drop", 32'(mem_req), 32'h0);
    chk("rr_err_clear", 32'(err_overrun), 32'h0);
    step(); step();
    reset_n = 1'b1;
    step(); step();
    chk("rr_no_rdy", 32'(rdy_cnt - rdy_mark), 32'h0);
    issue(24'h000301, 16'h0000, 2'b00);
    chk("rr_line_invalid", 32'(mem_req), 32'h1);
    chk("rr_refill_addr", 32'(mem_addr), 32'h000300);
    ack_once();
    feed(16'hD0D0); feed(16'hD1D1); feed(16'hD2D2); feed(16'hD3D3);
    chk("rr_refill_dout", 32'(sdr_cpu_dout), 32'hD1D1);
    step();

    // cache_en low: single-word read even though the line would hit.
    cache_en = 1'b0;
    issue(24'h000302, 16'h0000, 2'b00);
    chk("nc_req", 32'(mem_req), 32'h1);
    chk("nc_burst", 32'(mem_burst), 32'h0);
    chk("nc_addr", 32'(mem_addr), 32'h000302);
    ack_once();
    feed(16'hE0E0);
    chk("nc_rdy", 32'(sdr_cpu_rdy), 32'h1);
    chk("nc_dout", 32'(sdr_cpu_dout), 32'hE0E0);
    step();
    cache_en = 1'b1;
    issue(24'h000302, 16'h0000, 2'b00);
    chk("nc_line_kept_req", 32'(mem_req), 32'h0);
    step();
    chk("nc_line_kept", 32'(sdr_cpu_dout), 32'hD2D2);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
